// File: rtl/level2_mapper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : level2_mapper_pkg
//  Description : Shared constants and types for the level-2 address mapper:
//                register offsets, map_ctrl bit indices, decode targets and
//                host-sequencer states.
//  Revision    : 1.0 - initial release
// ============================================================================
package level2_mapper_pkg;

    // Register offsets (addr[3:0] within bank 8'b10xxxxxx)
    localparam logic [3:0] c_REG_MAP_CTRL = 4'd0;
    localparam logic [3:0] c_REG_PAGEREG  = 4'd1;
    localparam logic [3:0] c_REG_WIN_EN   = 4'd2;
    localparam logic [3:0] c_REG_RSVD     = 4'd3;
    localparam logic [3:0] c_REG_WIN_BASE = 4'd4;

    // map_ctrl bit indices
    localparam int c_MC_ROM_REMAP = 0;
    localparam int c_MC_RAM_REMAP = 1;
    localparam int c_MC_HS_EN     = 2;
    localparam int c_MC_TIMEOUT   = 7;

    // RAM remap is on at boot so the CPU can run from on-board RAM
    localparam logic [7:0]  c_MAP_CTRL_RESET   = 8'h02;

    localparam logic [15:0] c_HOST_IDLE_ADDR   = 16'h8000;
    localparam logic [15:0] c_PAGEREG_SNOOP    = 16'hFE30;
    localparam logic [7:0]  c_REMAP_BANK       = 8'hFE;
    localparam logic [7:0]  c_VECTOR_BANK      = 8'hFF;
    localparam logic [7:0]  c_HOST_TIMEOUT_DAT = 8'hFF;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_REG  = 2'd1,
        TGT_HOST = 2'd2
    } target_e;

    typedef enum logic [1:0] {
        HS_IDLE      = 2'd0,
        HS_WAIT_RISE = 2'd1,
        HS_HOST_HI   = 2'd2
    } host_state_e;

endpackage : level2_mapper_pkg
`default_nettype wire

// File: rtl/level2_mapper_host_seq.sv
`default_nettype none
// ============================================================================
//  Module      : level2_host_seq_m
//  Description : Host (BBC) bus cycle sequencer. Synchronises phi0, detects
//                its edges, runs one paced host read or write per start
//                request and aborts after HOST_TIMEOUT cycles without an edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module level2_host_seq_m
    import level2_mapper_pkg::*;
#(
    parameter int HOST_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_rnw,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_wdata,
    input  logic        i_phi0,
    input  logic [7:0]  i_bbc_rdata,
    output logic        o_busy,
    output logic        o_rd_done,
    output logic [7:0]  o_rd_data,
    output logic        o_timeout,
    output logic [15:0] o_bbc_addr,
    output logic        o_bbc_rnw,
    output logic [7:0]  o_bbc_wdata,
    output logic        o_bbc_wdata_oe
);

    localparam int                 c_CNT_W    = $clog2(HOST_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(HOST_TIMEOUT - 1);

    host_state_e        r_state;
    host_state_e        w_state_nxt;
    logic               r_phi_s1;
    logic               r_phi_s2;
    logic               r_phi_d;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_rnw;
    logic [15:0]        r_addr;
    logic [7:0]         r_wdata;
    logic               w_rise;
    logic               w_fall;
    logic               w_cnt_exp;
    logic               w_done;
    logic               w_active;

    assign w_rise    = r_phi_s2 & ~r_phi_d;
    assign w_fall    = ~r_phi_s2 & r_phi_d;
    assign w_cnt_exp = (r_cnt == c_CNT_LAST);
    assign w_active  = (r_state != HS_IDLE);

    // Two-flop phi0 synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phi_s1 <= 1'b0;
            r_phi_s2 <= 1'b0;
            r_phi_d  <= 1'b0;
        end else begin
            r_phi_s1 <= i_phi0;
            r_phi_s2 <= r_phi_s1;
            r_phi_d  <= r_phi_s2;
        end
    end

    // State register, timeout counter and latched cycle parameters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HS_IDLE;
            r_cnt   <= '0;
            r_rnw   <= 1'b1;
            r_addr  <= c_HOST_IDLE_ADDR;
            r_wdata <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_active) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (!w_active && i_start) begin
                r_rnw   <= i_rnw;
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
            end
        end
    end

    // Next-state: wait for phi0 rise, then finish on the following fall
    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        o_timeout   = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (i_start) begin
                    w_state_nxt = HS_WAIT_RISE;
                end
            end
            HS_WAIT_RISE: begin
                if (w_rise) begin
                    w_state_nxt = HS_HOST_HI;
                end else if (w_cnt_exp) begin
                    w_state_nxt = HS_IDLE;
                    w_done      = 1'b1;
                    o_timeout   = 1'b1;
                end
            end
            HS_HOST_HI: begin
                if (w_fall) begin
                    w_state_nxt = HS_IDLE;
                    w_done      = 1'b1;
                end else if (w_cnt_exp) begin
                    w_state_nxt = HS_IDLE;
                    w_done      = 1'b1;
                    o_timeout   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HS_IDLE;
            end
        endcase
    end

    assign o_busy    = w_active;
    assign o_rd_done = w_done & r_rnw;
    assign o_rd_data = o_timeout ? c_HOST_TIMEOUT_DAT : i_bbc_rdata;

    // Write strobe and data driver drop in the phi0-fall cycle itself
    assign o_bbc_addr     = w_active ? r_addr : c_HOST_IDLE_ADDR;
    assign o_bbc_rnw      = ~(w_active & ~r_rnw & ~((r_state == HS_HOST_HI) & w_fall));
    assign o_bbc_wdata    = r_wdata;
    assign o_bbc_wdata_oe = (r_state == HS_HOST_HI) & ~r_rnw & ~w_fall;

endmodule : level2_host_seq_m
`default_nettype wire

// File: rtl/level2_mapper_m.sv
`default_nettype none
// ============================================================================
//  Module      : level2_mapper_m
//  Description : 65816 address mapper and host-bus sequencer. Decodes each
//                CPU access to on-board RAM, internal registers or a paced
//                host bus cycle; provides NUM_WIN bank-0 remap windows and the
//                fast-clock request. Optional macro REMAP_NATIVE_INTERRUPTS_EN
//                forces native-mode vector fetches to RAM bank FF.
//  Revision    : 1.0 - initial release
// ============================================================================
module level2_mapper_m
    import level2_mapper_pkg::*;
#(
    parameter int NUM_WIN      = 2,
    parameter int RAM_AW       = 19,
    parameter int PAGEREG_W    = 4,
    parameter int HOST_TIMEOUT = 64
) (
    input  logic              bbc_ck8,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [23:0]       cpu_addr,
    input  logic              cpu_rnw,
    input  logic              cpu_vda,
    input  logic              cpu_vpa,
    input  logic              cpu_vpb,
    input  logic              cpu_e,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rdy,
    input  logic              bbc_phi0,
    input  logic [7:0]        bbc_rdata,
    output logic [15:0]       bbc_addr,
    output logic              bbc_rnw,
    output logic [7:0]        bbc_wdata,
    output logic              bbc_wdata_oe,
    output logic              ram_ce,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              hs_select
);

    // Mapper registers
    logic                 r_rom_remap;
    logic                 r_ram_remap;
    logic                 r_hs_en;
    logic                 r_timeout_flag;
    logic [PAGEREG_W-1:0] r_pagereg;
    logic [NUM_WIN-1:0]   r_win_en;
    logic [7:0]           r_win_range [NUM_WIN];
    logic [7:0]           r_win_bank  [NUM_WIN];

    // Registered outputs
    logic                 r_ram_ce;
    logic [RAM_AW-1:0]    r_ram_addr;
    logic [7:0]           r_cpu_rdata;
    logic                 r_hs_select;

    // Decode
    logic [7:0]           w_bank;
    logic [15:0]          w_addr;
    logic [3:0]           w_page;
    logic [3:0]           w_reg_off;
    logic                 w_bank0;
    logic                 w_accept;
    logic                 w_native;
    logic [NUM_WIN-1:0]   w_win_hit;
    logic [7:0]           w_win_bank;
    target_e              w_tgt;
    logic [23:0]          w_map_addr;
    logic                 w_shadow;
    logic                 w_snoop;
    logic                 w_reg_wr;
    logic                 w_host_start;
    logic [7:0]           w_map_ctrl;
    logic [7:0]           w_reg_rdata;

    // Host sequencer interface
    logic                 w_seq_busy;
    logic                 w_seq_rd_done;
    logic [7:0]           w_seq_rd_data;
    logic                 w_seq_timeout;

    assign w_bank    = cpu_addr[23:16];
    assign w_addr    = cpu_addr[15:0];
    assign w_page    = cpu_addr[15:12];
    assign w_reg_off = cpu_addr[3:0];
    assign w_bank0   = (w_bank == 8'h00);
    assign w_accept  = cpu_req & cpu_rdy;

`ifdef REMAP_NATIVE_INTERRUPTS_EN
    assign w_native = ~cpu_vpb & ~cpu_e;
`else
    logic w_unused_vec_status;
    assign w_unused_vec_status = cpu_vpb ^ cpu_e;
    assign w_native            = 1'b0;
`endif

    assign w_map_ctrl = {r_timeout_flag, 4'b0000, r_hs_en, r_ram_remap, r_rom_remap};

    // Per-window page range match
    generate
        for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
            assign w_win_hit[gi] = r_win_en[gi]
                                 && (w_page >= r_win_range[gi][3:0])
                                 && (w_page <= r_win_range[gi][7:4]);
        end
    endgenerate

    // Lowest-numbered matching window supplies the target bank
    always_comb begin
        w_win_bank = 8'h00;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (w_win_hit[i]) begin
                w_win_bank = r_win_bank[i];
            end
        end
    end

    // Priority decode of the current CPU access
    always_comb begin
        w_tgt      = TGT_HOST;
        w_map_addr = cpu_addr;
        w_shadow   = 1'b0;
        w_snoop    = 1'b0;
        if (w_native) begin
            w_tgt      = TGT_RAM;
            w_map_addr = {c_VECTOR_BANK, w_addr};
        end else if (w_bank[7:6] == 2'b10) begin
            w_tgt = TGT_REG;
        end else if (w_bank0 && (w_addr == c_PAGEREG_SNOOP) && !cpu_rnw) begin
            w_snoop = 1'b1;
        end else if (w_bank0 && (|w_win_hit)) begin
            w_tgt      = TGT_RAM;
            w_map_addr = {w_win_bank, w_addr};
        end else if (w_bank0 && !w_addr[15] && r_ram_remap) begin
            w_tgt      = TGT_RAM;
            w_map_addr = {c_REMAP_BANK, w_addr};
            // Screen memory writes must also reach the host for video
            w_shadow   = !cpu_rnw && w_addr[14];
        end else if (w_bank0 && (w_addr[15:14] == 2'b10) && r_rom_remap && (&r_pagereg)) begin
            w_tgt      = TGT_RAM;
            w_map_addr = {c_REMAP_BANK, w_addr};
        end else if (w_bank[7:6] == 2'b11) begin
            w_tgt = TGT_RAM;
        end
    end

    assign w_reg_wr     = w_accept && (w_tgt == TGT_REG) && !cpu_rnw;
    assign w_host_start = w_accept && ((w_tgt == TGT_HOST) || w_shadow);

    // Register read mux; unimplemented offsets read zero
    always_comb begin
        w_reg_rdata = 8'h00;
        case (w_reg_off)
            c_REG_MAP_CTRL: w_reg_rdata = w_map_ctrl;
            c_REG_PAGEREG:  w_reg_rdata = 8'(r_pagereg);
            c_REG_WIN_EN:   w_reg_rdata = 8'(r_win_en);
            c_REG_RSVD:     w_reg_rdata = 8'h00;
            default:        w_reg_rdata = 8'h00;
        endcase
        for (int i = 0; i < NUM_WIN; i++) begin
            if (w_reg_off == 4'(c_REG_WIN_BASE + 2 * i)) begin
                w_reg_rdata = r_win_range[i];
            end
            if (w_reg_off == 4'(c_REG_WIN_BASE + 2 * i + 1)) begin
                w_reg_rdata = r_win_bank[i];
            end
        end
    end

    // Mapper register writes, FE30 snoop and sticky timeout status
    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            r_rom_remap    <= c_MAP_CTRL_RESET[c_MC_ROM_REMAP];
            r_ram_remap    <= c_MAP_CTRL_RESET[c_MC_RAM_REMAP];
            r_hs_en        <= c_MAP_CTRL_RESET[c_MC_HS_EN];
            r_timeout_flag <= c_MAP_CTRL_RESET[c_MC_TIMEOUT];
            r_pagereg      <= '0;
            r_win_en       <= '0;
            for (int i = 0; i < NUM_WIN; i++) begin
                r_win_range[i] <= 8'h00;
                r_win_bank[i]  <= 8'h00;
            end
        end else begin
            if (w_reg_wr && (w_reg_off == c_REG_MAP_CTRL)) begin
                r_rom_remap    <= cpu_wdata[c_MC_ROM_REMAP];
                r_ram_remap    <= cpu_wdata[c_MC_RAM_REMAP];
                r_hs_en        <= cpu_wdata[c_MC_HS_EN];
                r_timeout_flag <= 1'b0;
            end
            if (w_reg_wr && (w_reg_off == c_REG_PAGEREG)) begin
                r_pagereg <= cpu_wdata[PAGEREG_W-1:0];
            end
            if (w_accept && w_snoop) begin
                r_pagereg <= cpu_wdata[PAGEREG_W-1:0];
            end
            if (w_reg_wr && (w_reg_off == c_REG_WIN_EN)) begin
                r_win_en <= cpu_wdata[NUM_WIN-1:0];
            end
            for (int i = 0; i < NUM_WIN; i++) begin
                if (w_reg_wr && (w_reg_off == 4'(c_REG_WIN_BASE + 2 * i))) begin
                    r_win_range[i] <= cpu_wdata;
                end
                if (w_reg_wr && (w_reg_off == 4'(c_REG_WIN_BASE + 2 * i + 1))) begin
                    r_win_bank[i] <= cpu_wdata;
                end
            end
            if (w_seq_timeout) begin
                r_timeout_flag <= 1'b1;
            end
        end
    end

    // RAM strobe/address and CPU read data, one cycle after the request
    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            r_ram_ce    <= 1'b0;
            r_ram_addr  <= '0;
            r_cpu_rdata <= 8'h00;
        end else begin
            r_ram_ce <= w_accept && (w_tgt == TGT_RAM);
            if (w_accept && (w_tgt == TGT_RAM)) begin
                r_ram_addr <= RAM_AW'(w_map_addr);
            end
            if (w_accept && (w_tgt == TGT_REG) && cpu_rnw) begin
                r_cpu_rdata <= w_reg_rdata;
            end else if (w_seq_rd_done) begin
                r_cpu_rdata <= w_seq_rd_data;
            end
        end
    end

    // Fast-clock request: set by local opcode fetches, dropped by host work
    always_ff @(posedge bbc_ck8) begin
        if (reset) begin
            r_hs_select <= 1'b0;
        end else if (!r_hs_en || w_host_start) begin
            r_hs_select <= 1'b0;
        end else if (w_accept && cpu_vpa && cpu_vda) begin
            r_hs_select <= 1'b1;
        end
    end

    level2_host_seq_m #(
        .HOST_TIMEOUT (HOST_TIMEOUT)
    ) u_host_seq (
        .clk            (bbc_ck8),
        .rst            (reset),
        .i_start        (w_host_start),
        .i_rnw          (cpu_rnw),
        .i_addr         (w_addr),
        .i_wdata        (cpu_wdata),
        .i_phi0         (bbc_phi0),
        .i_bbc_rdata    (bbc_rdata),
        .o_busy         (w_seq_busy),
        .o_rd_done      (w_seq_rd_done),
        .o_rd_data      (w_seq_rd_data),
        .o_timeout      (w_seq_timeout),
        .o_bbc_addr     (bbc_addr),
        .o_bbc_rnw      (bbc_rnw),
        .o_bbc_wdata    (bbc_wdata),
        .o_bbc_wdata_oe (bbc_wdata_oe)
    );

    assign cpu_rdy   = ~w_seq_busy;
    assign cpu_rdata = r_cpu_rdata;
    assign ram_ce    = r_ram_ce;
    assign ram_addr  = r_ram_addr;
    assign hs_select = r_hs_select;

endmodule : level2_mapper_m
`default_nettype wire

// File: tb/tb_level2_mapper_m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_level2_mapper_m
//  Description : Directed self-checking bench for level2_mapper_m.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_level2_mapper_m;

    localparam int RAM_AW = 19;

    logic              bbc_ck8   = 1'b0;
    logic              reset     = 1'b1;
    logic              cpu_req   = 1'b0;
    logic [23:0]       cpu_addr  = 24'h0;
    logic              cpu_rnw   = 1'b1;
    logic              cpu_vda   = 1'b0;
    logic              cpu_vpa   = 1'b0;
    logic              cpu_vpb   = 1'b1;
    logic              cpu_e     = 1'b1;
    logic [7:0]        cpu_wdata = 8'h00;
    logic              bbc_phi0  = 1'b0;
    logic [7:0]        bbc_rdata = 8'h00;
    logic              phi_en    = 1'b1;
    logic [7:0]        cpu_rdata;
    logic              cpu_rdy;
    logic [15:0]       bbc_addr;
    logic              bbc_rnw;
    logic [7:0]        bbc_wdata;
    logic              bbc_wdata_oe;
    logic              ram_ce;
    logic [RAM_AW-1:0] ram_addr;
    logic              hs_select;

    int checks = 0;
    int errors = 0;

    level2_mapper_m #(
        .NUM_WIN(2), .RAM_AW(RAM_AW), .PAGEREG_W(4), .HOST_TIMEOUT(64)
    ) dut (
        .bbc_ck8(bbc_ck8), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_rnw(cpu_rnw), .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_vpb(cpu_vpb),
        .cpu_e(cpu_e), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdy(cpu_rdy),
        .bbc_phi0(bbc_phi0), .bbc_rdata(bbc_rdata), .bbc_addr(bbc_addr), .bbc_rnw(bbc_rnw),
        .bbc_wdata(bbc_wdata), .bbc_wdata_oe(bbc_wdata_oe), .ram_ce(ram_ce),
        .ram_addr(ram_addr), .hs_select(hs_select)
    );

    always #5 bbc_ck8 = ~bbc_ck8;
    // Host phi0: 8 bbc_ck8 cycles per period, or held low when disabled
    always #40 bbc_phi0 = phi_en ? ~bbc_phi0 : 1'b0;

    function automatic logic [RAM_AW-1:0] ram_of(input logic [23:0] a);
        return a[RAM_AW-1:0];
    endfunction

    // One-cycle request; returns at the negedge of the cycle after it
    task automatic issue(input logic [23:0] a, input logic rnw, input logic [7:0] d, input logic fetch);
        @(negedge bbc_ck8);
        cpu_addr  = a;
        cpu_rnw   = rnw;
        cpu_wdata = d;
        cpu_vpa   = fetch;
        cpu_vda   = 1'b1;
        cpu_req   = 1'b1;
        @(negedge bbc_ck8);
        cpu_req   = 1'b0;
        cpu_vpa   = 1'b0;
        cpu_vda   = 1'b0;
        cpu_rnw   = 1'b1;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!cpu_rdy && n < 200) begin
            n++;
            @(negedge bbc_ck8);
        end
    endtask

    task automatic reg_write(input logic [3:0] off, input logic [7:0] d);
        issue({8'h80, 12'h000, off}, 1'b0, d, 1'b0);
    endtask

    task automatic reg_read(input logic [3:0] off, output logic [7:0] d);
        issue({8'h80, 12'h000, off}, 1'b1, 8'h00, 1'b0);
        d = cpu_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        repeat (3) @(negedge bbc_ck8);
        checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", cpu_rdy); end
        checks++; if (cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", cpu_rdata); end
        checks++; if (bbc_rnw !== 1'b1 || bbc_wdata_oe !== 1'b0) begin errors++; $display("FAIL reset_bbc_ctl: got rnw=%b oe=%b expected 1/0", bbc_rnw, bbc_wdata_oe); end
        checks++; if (bbc_addr !== 16'h8000) begin errors++; $display("FAIL reset_bbc_addr: got %h expected 8000", bbc_addr); end
        checks++; if (ram_ce !== 1'b0 || hs_select !== 1'b0) begin errors++; $display("FAIL reset_ce_hs: got ce=%b hs=%b expected 0/0", ram_ce, hs_select); end
        reset = 1'b0;
        reg_read(4'd0, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL reset_map_ctrl: got %h expected 02", d); end
    endtask

    task automatic test_ram_remap();
        issue(24'h001234, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_ce !== 1'b1) begin errors++; $display("FAIL ram_remap_ce: got %b expected 1", ram_ce); end
        checks++; if (ram_addr !== ram_of(24'hFE1234)) begin errors++; $display("FAIL ram_remap_addr: got %h expected %h", ram_addr, ram_of(24'hFE1234)); end
        checks++; if (cpu_rdy !== 1'b1) begin errors++; $display("FAIL ram_remap_rdy: got %b expected 1", cpu_rdy); end
        @(negedge bbc_ck8);
        checks++; if (ram_ce !== 1'b0 || cpu_rdy !== 1'b1) begin errors++; $display("FAIL ram_remap_after: got ce=%b rdy=%b expected 0/1", ram_ce, cpu_rdy); end
    endtask

    task automatic test_rom_remap();
        logic [7:0] d;
        int n;
        reg_write(4'd1, 8'h0F);
        reg_write(4'd0, 8'h03);
        reg_read(4'd1, d);
        checks++; if (d !== 8'h0F) begin errors++; $display("FAIL pagereg_rd: got %h expected 0F", d); end
        issue(24'h009000, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_ce !== 1'b1 || ram_addr !== ram_of(24'hFE9000) || cpu_rdy !== 1'b1) begin
            errors++; $display("FAIL rom_remap_ram: got ce=%b addr=%h rdy=%b expected 1/%h/1", ram_ce, ram_addr, cpu_rdy, ram_of(24'hFE9000)); end
        reg_write(4'd1, 8'h03);
        bbc_rdata = 8'hA7;
        issue(24'h009000, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_ce !== 1'b0 || cpu_rdy !== 1'b0) begin errors++; $display("FAIL rom_host_start: got ce=%b rdy=%b expected 0/0", ram_ce, cpu_rdy); end
        checks++; if (bbc_addr !== 16'h9000 || bbc_rnw !== 1'b1) begin errors++; $display("FAIL rom_host_addr: got %h rnw=%b expected 9000/1", bbc_addr, bbc_rnw); end
        wait_rdy(n);
        checks++; if (n >= 200) begin errors++; $display("FAIL rom_host_wait: got %0d cycles expected <200", n); end
        checks++; if (cpu_rdata !== 8'hA7) begin errors++; $display("FAIL rom_host_rdata: got %h expected A7", cpu_rdata); end
        checks++; if (bbc_addr !== 16'h8000) begin errors++; $display("FAIL rom_host_idle_addr: got %h expected 8000", bbc_addr); end
    endtask

    task automatic test_window();
        reg_write(4'd4, 8'h32);
        reg_write(4'd5, 8'hC4);
        reg_write(4'd6, 8'h33);
        reg_write(4'd7, 8'hC8);
        reg_write(4'd2, 8'h03);
        issue(24'h003FFF, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_ce !== 1'b1 || ram_addr !== ram_of(24'hC43FFF)) begin errors++; $display("FAIL win_hi: got ce=%b addr=%h expected 1/%h", ram_ce, ram_addr, ram_of(24'hC43FFF)); end
        issue(24'h002000, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_addr !== ram_of(24'hC42000)) begin errors++; $display("FAIL win_lo: got %h expected %h", ram_addr, ram_of(24'hC42000)); end
        issue(24'h004000, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_addr !== ram_of(24'hFE4000)) begin errors++; $display("FAIL win_above: got %h expected %h", ram_addr, ram_of(24'hFE4000)); end
        issue(24'h001FFF, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_addr !== ram_of(24'hFE1FFF)) begin errors++; $display("FAIL win_below: got %h expected %h", ram_addr, ram_of(24'hFE1FFF)); end
        reg_write(4'd2, 8'h02);
        issue(24'h003000, 1'b1, 8'h00, 1'b0);
        checks++; if (ram_addr !== ram_of(24'hC83000)) begin errors++; $display("FAIL win1_only: got %h expected %h", ram_addr, ram_of(24'hC83000)); end
        reg_write(4'd2, 8'h00);
    endtask

    task automatic test_shadow_write();
        int n;
        int bad;
        logic seen;
        issue(24'h005000, 1'b0, 8'h5A, 1'b0);
        checks++; if (ram_ce !== 1'b1 || ram_addr !== ram_of(24'hFE5000)) begin errors++; $display("FAIL shadow_ram: got ce=%b addr=%h expected 1/%h", ram_ce, ram_addr, ram_of(24'hFE5000)); end
        checks++; if (cpu_rdy !== 1'b0) begin errors++; $display("FAIL shadow_rdy: got %b expected 0", cpu_rdy); end
        n = 0; bad = 0; seen = 1'b0;
        while (!cpu_rdy && n < 200) begin
            if (bbc_wdata_oe) begin
                seen = 1'b1;
                if (bbc_wdata !== 8'h5A || bbc_rnw !== 1'b0 || bbc_addr !== 16'h5000) bad++;
            end
            n++;
            @(negedge bbc_ck8);
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL shadow_wait: got %0d cycles expected <200", n); end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL shadow_oe_seen: got %b expected 1", seen); end
        checks++; if (bad != 0) begin errors++; $display("FAIL shadow_host_data: got %0d bad cycles expected 0", bad); end
        checks++; if (bbc_wdata_oe !== 1'b0 || bbc_rnw !== 1'b1) begin errors++; $display("FAIL shadow_release: got oe=%b rnw=%b expected 0/1", bbc_wdata_oe, bbc_rnw); end
    endtask

    task automatic test_snoop();
        logic [7:0] d;
        int n;
        issue(24'h00FE30, 1'b0, 8'h0F, 1'b0);
        checks++; if (ram_ce !== 1'b0 || cpu_rdy !== 1'b0) begin errors++; $display("FAIL snoop_host: got ce=%b rdy=%b expected 0/0", ram_ce, cpu_rdy); end
        wait_rdy(n);
        reg_read(4'd1, d);
        checks++; if (d !== 8'h0F) begin errors++; $display("FAIL snoop_pagereg: got %h expected 0F", d); end
    endtask

    task automatic test_timeout();
        logic [7:0] d;
        int n;
        phi_en = 1'b0;
        repeat (12) @(negedge bbc_ck8);
        issue(24'h00C000, 1'b1, 8'h00, 1'b0);
        wait_rdy(n);
        checks++; if (n != 64) begin errors++; $display("FAIL timeout_cycles: got %0d expected 64", n); end
        checks++; if (cpu_rdata !== 8'hFF) begin errors++; $display("FAIL timeout_rdata: got %h expected FF", cpu_rdata); end
        reg_read(4'd0, d);
        checks++; if (d !== 8'h83) begin errors++; $display("FAIL timeout_flag: got %h expected 83", d); end
        reg_write(4'd0, 8'h03);
        reg_read(4'd0, d);
        checks++; if (d !== 8'h03) begin errors++; $display("FAIL timeout_clear: got %h expected 03", d); end
        phi_en = 1'b1;
    endtask

    task automatic test_hs_select();
        int n;
        reg_write(4'd0, 8'h07);
        issue(24'hC00100, 1'b1, 8'h00, 1'b1);
        checks++; if (hs_select !== 1'b1) begin errors++; $display("FAIL hs_set: got %b expected 1", hs_select); end
        issue(24'hC00101, 1'b1, 8'h00, 1'b0);
        @(negedge bbc_ck8);
        checks++; if (hs_select !== 1'b1) begin errors++; $display("FAIL hs_hold: got %b expected 1", hs_select); end
        issue(24'h00C000, 1'b1, 8'h00, 1'b0);
        checks++; if (hs_select !== 1'b0) begin errors++; $display("FAIL hs_host_clear: got %b expected 0", hs_select); end
        wait_rdy(n);
        issue(24'hC00102, 1'b1, 8'h00, 1'b1);
        reg_write(4'd0, 8'h03);
        @(negedge bbc_ck8);
        checks++; if (hs_select !== 1'b0) begin errors++; $display("FAIL hs_en_clear: got %b expected 0", hs_select); end
    endtask

    task automatic test_native();
        int n;
        cpu_vpb = 1'b0;
        cpu_e   = 1'b0;
        issue(24'h00FFEA, 1'b1, 8'h00, 1'b0);
`ifdef REMAP_NATIVE_INTERRUPTS_EN
        checks++; if (ram_ce !== 1'b1 || ram_addr !== ram_of(24'hFFFFEA) || cpu_rdy !== 1'b1) begin
            errors++; $display("FAIL native_vector: got ce=%b addr=%h rdy=%b expected 1/%h/1", ram_ce, ram_addr, cpu_rdy, ram_of(24'hFFFFEA)); end
`else
        checks++; if (ram_ce !== 1'b0 || cpu_rdy !== 1'b0 || bbc_addr !== 16'hFFEA) begin
            errors++; $display("FAIL native_vector: got ce=%b rdy=%b addr=%h expected 0/0/FFEA", ram_ce, cpu_rdy, bbc_addr); end
`endif
        wait_rdy(n);
        cpu_vpb = 1'b1;
        cpu_e   = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int n;
        issue(24'h00C000, 1'b0, 8'h11, 1'b0);
        n = 0;
        while (!bbc_wdata_oe && n < 200) begin
            n++;
            @(negedge bbc_ck8);
        end
        checks++; if (n >= 200) begin errors++; $display("FAIL mid_oe_wait: got %0d cycles expected <200", n); end
        reset = 1'b1;
        @(negedge bbc_ck8);
        checks++; if (bbc_wdata_oe !== 1'b0 || bbc_rnw !== 1'b1 || cpu_rdy !== 1'b1 || bbc_addr !== 16'h8000) begin
            errors++; $display("FAIL mid_reset: got oe=%b rnw=%b rdy=%b addr=%h expected 0/1/1/8000", bbc_wdata_oe, bbc_rnw, cpu_rdy, bbc_addr); end
        reset = 1'b0;
        reg_read(4'd0, d);
        checks++; if (d !== 8'h02) begin errors++; $display("FAIL mid_map_ctrl: got %h expected 02", d); end
    endtask

    initial begin
        test_reset();
        test_ram_remap();
        test_rom_remap();
        test_window();
        test_shadow_write();
        test_snoop();
        test_timeout();
        test_hs_select();
        test_native();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_level2_mapper_m
`default_nettype wire
